// File: rtl/pc_pkg.sv
// Shared types and constants for the program-counter fetch controller.
package pc_pkg;

    localparam int unsigned LUT_IDX_W = 5;
    localparam int unsigned PC_W_DEF  = 12;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } pc_state_e;

endpackage

// File: rtl/pc_ras.sv
// Return-address stack: LIFO of DEPTH program-counter values.
// The caller never asserts push and pop together and never pushes when full
// or pops when empty; those cases are filtered upstream.
module pc_ras #(
    parameter int unsigned D     = 12,
    parameter int unsigned DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [D-1:0] push_data,
    output logic         full,
    output logic         empty,
    output logic [D-1:0] top
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [D-1:0]     r_mem [DEPTH];
    logic [CNT_W-1:0] r_cnt;
    logic [IDX_W-1:0] w_wr_idx;
    logic [IDX_W-1:0] w_rd_idx;

    assign w_wr_idx = IDX_W'(r_cnt);
    assign w_rd_idx = IDX_W'(r_cnt - CNT_W'(1));

    assign full  = (r_cnt == CNT_W'(DEPTH));
    assign empty = (r_cnt == '0);
    assign top   = r_mem[w_rd_idx];

    // Stack storage and occupancy count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
        end else if (push) begin
            r_mem[w_wr_idx] <= push_data;
            r_cnt           <= r_cnt + CNT_W'(1);
        end else if (pop) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Program-counter fetch controller: IDLE/RUN/DONE sequencing, LUT branches,
// and an optional return-address stack compiled in with PC_RAS_EN.
module pc_fetch_ctrl
    import pc_pkg::*;
#(
    parameter int unsigned D         = PC_W_DEF,
    parameter int unsigned RAS_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [D-1:0]         start_addr,
    input  logic                 halt,
    input  logic                 branch_en,
    input  logic                 branch_taken,
    input  logic                 call_en,
    input  logic                 ret_en,
    input  logic [LUT_IDX_W-1:0] lut_idx,
    output logic [LUT_IDX_W-1:0] lut_addr,
    input  logic [D-1:0]         lut_target,
    output logic [D-1:0]         prog_ctr,
    output logic                 running,
    output logic                 done,
    output logic                 ras_err
);

    pc_state_e    r_state;
    pc_state_e    w_state_nxt;
    logic [D-1:0] r_prog_ctr;
    logic [D-1:0] w_pc_nxt;
    logic [D-1:0] w_pc_inc;
    logic         r_running;
    logic         r_done;

`ifdef PC_RAS_EN
    logic         r_ras_err;
    logic         w_err_nxt;
    logic         w_push;
    logic         w_pop;
    logic         w_full;
    logic         w_empty;
    logic [D-1:0] w_top;

    // Return-address stack; pushes the address after the call.
    pc_ras #(
        .D     (D),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (w_push),
        .pop       (w_pop),
        .push_data (w_pc_inc),
        .full      (w_full),
        .empty     (w_empty),
        .top       (w_top)
    );

    assign ras_err = r_ras_err;
`else
    logic w_unused_ras;

    assign w_unused_ras = ^{call_en, ret_en};
    assign ras_err      = 1'b0;
`endif

    assign lut_addr = lut_idx;
    assign w_pc_inc = r_prog_ctr + D'(1);
    assign prog_ctr = r_prog_ctr;
    assign running  = r_running;
    assign done     = r_done;

    // Next-state and next-PC selection: halt > ret > call > taken branch > increment.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_prog_ctr;
`ifdef PC_RAS_EN
        w_err_nxt   = r_ras_err;
        w_push      = 1'b0;
        w_pop       = 1'b0;
`endif
        case (r_state)
            IDLE, DONE: begin
                if (start) begin
                    w_state_nxt = RUN;
                    w_pc_nxt    = start_addr;
`ifdef PC_RAS_EN
                    w_err_nxt   = 1'b0;
`endif
                end
            end
            RUN: begin
                if (halt) begin
                    w_state_nxt = DONE;
                end
`ifdef PC_RAS_EN
                else if (ret_en) begin
                    if (w_empty) begin
                        w_pc_nxt  = w_pc_inc;
                        w_err_nxt = 1'b1;
                    end else begin
                        w_pc_nxt = w_top;
                        w_pop    = 1'b1;
                    end
                end else if (call_en) begin
                    w_pc_nxt = lut_target;
                    if (w_full) begin
                        w_err_nxt = 1'b1;
                    end else begin
                        w_push = 1'b1;
                    end
                end
`endif
                else if (branch_en && branch_taken && (lut_idx != '0)) begin
                    w_pc_nxt = lut_target;
                end else begin
                    w_pc_nxt = w_pc_inc;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State, program counter and status flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_prog_ctr <= '0;
            r_running  <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_prog_ctr <= w_pc_nxt;
            r_running  <= (w_state_nxt == RUN);
            r_done     <= (w_state_nxt == DONE);
        end
    end

`ifdef PC_RAS_EN
    // Sticky stack-error flag, cleared by reset or an accepted start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ras_err <= 1'b0;
        end else begin
            r_ras_err <= w_err_nxt;
        end
    end
`endif

endmodule
